// File: rtl/sw_debounce.sv
// sw_debounce: 8-bit synchronized switch debouncer; define SW_DEBOUNCE_EDGE_EN for registered sw_rise/sw_fall pulses
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] SW,
  output logic [7:0] sw_clean,
  output logic [7:0] sw_rise,
  output logic [7:0] sw_fall,
  output logic       changed
);
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic [7:0] s1, s2, flip;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic [15:0] cnt;
    assign flip[i] = (s2[i] != sw_clean[i]) && (cnt == LAST);
    always_ff @(posedge clk)
      cnt <= (rst || s2[i] == sw_clean[i] || flip[i]) ? 16'd0 : cnt + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      sw_clean <= '0;
      changed  <= 1'b0;
    end else begin
      s1       <= SW;
      s2       <= s1;
      sw_clean <= sw_clean ^ flip;
      changed  <= |flip;
    end
  end
`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    sw_rise <= rst ? 8'h00 : flip & s2;
    sw_fall <= rst ? 8'h00 : flip & ~s2;
  end
`else
  assign sw_rise = 8'h00;
  assign sw_fall = 8'h00;
`endif
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive synchronized cycles an input bit must differ from its clean value before the clean value updates; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 SW  input  8  raw, asynchronous, bouncing slide-switch levels.
REQ-005 sw_clean  output  8  debounced, synchronized switch levels.
REQ-006 sw_rise  output  8  per-bit one-cycle pulse on a sw_clean 0->1 transition.
REQ-007 sw_fall  output  8  per-bit one-cycle pulse on a sw_clean 1->0 transition.
REQ-008 changed  output  1  one-cycle pulse when any sw_clean bit transitions.

Function
REQ-009 Each SW bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-010 Each bit SHALL have an independent 16-bit counter; all eight bits operate identically and independently.
REQ-011 When s2[i] equals sw_clean[i], counter[i] SHALL load 0 on that edge.
REQ-012 When s2[i] differs from sw_clean[i] and counter[i] is below DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-013 When s2[i] differs from sw_clean[i] and counter[i] equals DEBOUNCE_CYCLES-1, sw_clean[i] SHALL take s2[i] and counter[i] SHALL load 0 on the same edge.
REQ-014 Latency: if SW[i] changes before edge k and stays stable, sw_clean[i] SHALL change at edge k+1+DEBOUNCE_CYCLES and not earlier.
REQ-015 A level on s2[i] that differs from sw_clean[i] for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL NOT change sw_clean[i].
REQ-016 sw_rise[i]/sw_fall[i] SHALL be registered and high for exactly the first cycle in which sw_clean[i] shows its new value.
REQ-017 changed SHALL be registered, high for exactly one cycle, in the same cycle as any sw_rise or sw_fall bit would be high.
REQ-018 Simultaneous transitions on several bits SHALL assert all their pulse bits in the same cycle with a single-cycle changed.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While rst is high at an edge, s1, s2, sw_clean, all counters, sw_rise, sw_fall and changed SHALL load 0.
REQ-021 Reset asserted mid-count SHALL discard partial counts; no pulse SHALL be generated by reset itself.
REQ-022 If SW is held nonzero across reset release, the affected sw_clean bits SHALL rise per REQ-014 measured from the first non-reset edge, with sw_rise pulses.

Configuration
REQ-023 Macro SW_DEBOUNCE_EDGE_EN defined: sw_rise and sw_fall SHALL behave per REQ-016.
REQ-024 Macro SW_DEBOUNCE_EDGE_EN undefined: sw_rise and sw_fall SHALL remain ports, constant 0, with no edge registers; sw_clean and changed are unaffected.

Verification (DEBOUNCE_CYCLES=4 unless noted)
REQ-025 Reset, SW=8'h00 stable -> sw_clean=8'h00, all pulses 0 for 50 cycles.
REQ-026 SW 8'h00->8'h01 before edge k, held -> sw_clean=8'h01 at edge k+5; sw_rise=8'h01 and changed=1 for exactly that cycle only.
REQ-027 SW[3] toggled 1-0-1-0 each cycle for 6 cycles, then held 1 -> no change until 5 edges after final transition; single sw_rise[3] pulse.
REQ-028 SW 8'hF0->8'h0F in one cycle from settled 8'hF0 -> sw_clean=8'h0F at one edge; sw_rise=8'h0F, sw_fall=8'hF0, changed=1 same cycle.
REQ-029 SW[0] high 3 cycles then rst pulsed 1 cycle, SW[0] held high -> no pulse during reset; sw_clean[0]=1 at 5 edges after first non-reset edge.
REQ-030 DEBOUNCE_CYCLES=1, macro undefined, SW 8'h00->8'hAA -> sw_clean=8'hAA at edge k+2, sw_rise=sw_fall=0 always, changed pulses once.
